// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one Fibonacci LFSR among NREQ requesters.
// Optional statistics counters are enabled with `define LFSR_SCHED_STATS_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | apply a pending seed, otherwise arbitrate among req bits
// STEP  | shift the LFSR once per cycle, STEPS cycles in total
// ACK   | register one-hot grant + rnd_valid, advance round-robin pointer
module lfsr_rr_sched #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1101,
  parameter logic [WIDTH-1:0]   SEED  = 4'b0001,
  parameter int                 NREQ  = 4,
  parameter int                 STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [NREQ-1:0]  grant,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic             busy
`ifdef LFSR_SCHED_STATS_EN
  ,
  output logic [15:0]      word_count,
  output logic [7:0]       reseed_count
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           fsm;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_q;
  logic             seed_pend;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [CW-1:0]    cnt;

  logic             arb_hit;
  logic [PW-1:0]    arb_idx;
  logic             fb;

  assign fb      = ^(lfsr & TAPS);
  assign rnd_out = lfsr;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    int j;
    arb_hit = 1'b0;
    arb_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!arb_hit && req[j]) begin
        arb_hit = 1'b1;
        arb_idx = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      lfsr      <= SEED;
      seed_q    <= '0;
      seed_pend <= 1'b0;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      grant     <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef LFSR_SCHED_STATS_EN
      word_count   <= '0;
      reseed_count <= '0;
`endif
    end else begin
      grant     <= '0;
      rnd_valid <= 1'b0;
      if (seed_load) begin
        seed_pend <= 1'b1;
        seed_q    <= seed_in;
      end
      case (fsm)
        IDLE: begin
          if (seed_pend) begin
            // An all-zero seed would lock the LFSR, so fall back to SEED.
            lfsr <= (seed_q == '0) ? SEED : seed_q;
            if (!seed_load) seed_pend <= 1'b0;
`ifdef LFSR_SCHED_STATS_EN
            if (reseed_count != 8'hFF) reseed_count <= reseed_count + 8'd1;
`endif
          end else if (!seed_load && arb_hit) begin
            win  <= arb_idx;
            cnt  <= CW'(STEPS - 1);
            busy <= 1'b1;
            fsm  <= STEP;
          end
        end
        STEP: begin
          lfsr <= {lfsr[WIDTH-2:0], fb};
          if (cnt == '0) fsm <= ACK;
          else           cnt <= cnt - CW'(1);
        end
        ACK: begin
          grant     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
          rnd_valid <= 1'b1;
          busy      <= 1'b0;
          ptr       <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          fsm       <= IDLE;
`ifdef LFSR_SCHED_STATS_EN
          if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
`endif
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched: default instance plus a STEPS=3 instance.
// Expected words come from hand-stepping the 4-bit LFSR with TAPS=1101.
module tb_lfsr_rr_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req, req3;
  logic       seed_load, seed_load3;
  logic [3:0] seed_in, seed_in3;
  logic [3:0] grant, grant3;
  logic       rnd_valid, rnd_valid3;
  logic [3:0] rnd_out, rnd_out3;
  logic       busy, busy3;
`ifdef LFSR_SCHED_STATS_EN
  logic [15:0] word_count, word_count3;
  logic [7:0]  reseed_count, reseed_count3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_rr_sched dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .grant(grant), .rnd_valid(rnd_valid), .rnd_out(rnd_out), .busy(busy)
`ifdef LFSR_SCHED_STATS_EN
    , .word_count(word_count), .reseed_count(reseed_count)
`endif
  );

  lfsr_rr_sched #(.STEPS(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .seed_load(seed_load3), .seed_in(seed_in3),
    .grant(grant3), .rnd_valid(rnd_valid3), .rnd_out(rnd_out3), .busy(busy3)
`ifdef LFSR_SCHED_STATS_EN
    , .word_count(word_count3), .reseed_count(reseed_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for rnd_valid, then checks latency, grant, word and busy cycles.
  task automatic expect_grant(input string tag, input bit sel, input logic [3:0] exp_g,
                              input logic [3:0] exp_r, input int exp_wait, input int exp_busy);
    int n  = 0;
    int nb = 0;
    bit got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (sel ? rnd_valid3 : rnd_valid) got = 1'b1;
      else if (sel ? busy3 : busy) nb++;
    end
    check({tag, "_seen"},  32'(got), 32'd1);
    check({tag, "_wait"},  32'(n), 32'(exp_wait));
    check({tag, "_grant"}, 32'(sel ? grant3 : grant), 32'(exp_g));
    check({tag, "_word"},  32'(sel ? rnd_out3 : rnd_out), 32'(exp_r));
    check({tag, "_busy"},  32'(nb), 32'(exp_busy));
  endtask

  logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_r [5] = '{4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

  initial begin
    int seen;
    rst = 1'b1; req = '0; seed_load = 1'b0; seed_in = '0;
    req3 = '0; seed_load3 = 1'b0; seed_in3 = '0;
    repeat (3) @(negedge clk);
    check("rst_word",  32'(rnd_out), 32'h1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(rnd_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single request
    req = 4'b0001;
    expect_grant("single", 1'b0, 4'b0001, 4'b0011, 3, 2);
    req = '0;
    @(negedge clk);
    check("single_grant_off", 32'(grant), 32'h0);
    check("single_valid_off", 32'(rnd_valid), 32'h0);

    // Round-robin under full contention
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++)
      expect_grant($sformatf("rr%0d", k), 1'b0, rr_g[k], rr_r[k], 3, 2);
    req = '0;
    @(negedge clk);

    // Seed latency and zero-seed substitution
    do_reset();
    seed_in = 4'b1000; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed_latency", 32'(rnd_out), 32'h1);
    @(negedge clk);
    check("seed_applied", 32'(rnd_out), 32'h8);
    check("seed_no_busy", 32'(busy), 32'h0);
    seed_in = 4'b0000; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    check("zero_seed_sub", 32'(rnd_out), 32'h1);

    // Reseed while busy: word delivered unchanged, seed lands after, next grant one cycle late
    req = 4'b0001;
    @(negedge clk);
    check("rsd_busy", 32'(busy), 32'h1);
    seed_in = 4'b0111; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    expect_grant("rsd_word", 1'b0, 4'b0001, 4'b0011, 1, 0);
    @(negedge clk);
    check("rsd_apply", 32'(rnd_out), 32'h7);
    check("rsd_idle",  32'(busy), 32'h0);
    expect_grant("rsd_late", 1'b0, 4'b0001, 4'b1110, 3, 2);
    req = '0;
    @(negedge clk);

    // Reset mid-STEP aborts the transaction
    req = 4'b0010;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_word",  32'(rnd_out), 32'h1);
    check("abort_busy",  32'(busy), 32'h0);
    check("abort_grant", 32'(grant), 32'h0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rnd_valid || grant != '0) seen++;
    end
    check("abort_no_grant", 32'(seen), 32'h0);
    req = 4'b0100;
    expect_grant("post_rst", 1'b0, 4'b0100, 4'b0011, 3, 2);
    // Pointer now at 3: requester 3 wins, then the scan wraps to requester 0
    req = 4'b1001;
    expect_grant("wrap_hi", 1'b0, 4'b1000, 4'b0111, 3, 2);
    expect_grant("wrap_lo", 1'b0, 4'b0001, 4'b1110, 3, 2);
    req = '0;
    @(negedge clk);

    // STEPS=3 instance
    req3 = 4'b0001;
    expect_grant("steps3", 1'b1, 4'b0001, 4'b1110, 5, 4);
    req3 = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
